// File: rtl/dsp_mac_engine_if.sv
// Operand/result bundle for dsp_mac_engine: inputs qualified by in_valid, results marked by p_valid.
// No backpressure; ce is the only throttle and stalls the whole pipeline.
interface dsp_mac_engine_if #(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int PW = 48
);
    logic              ce;
    logic              in_valid;
    logic [AW-1:0]     a;
    logic [BW-1:0]     b;
    logic [BW-1:0]     d;
    logic [PW-1:0]     c;
    logic [5:0]        opmode;
    logic              carryin;
    logic [AW+BW:0]    m;
    logic [PW-1:0]     p;
    logic              p_valid;
    logic              carryout;
    logic              sat;

    modport master (
        output ce, in_valid, a, b, d, c, opmode, carryin,
        input  m, p, p_valid, carryout, sat
    );

    modport slave (
        input  ce, in_valid, a, b, d, c, opmode, carryin,
        output m, p, p_valid, carryout, sat
    );
endinterface

// File: rtl/dsp_mac_engine.sv
// Four-stage pre-add / multiply / post-add MAC with dot-product grouping; result 4 enabled edges after accept.
// No backpressure: one sample per enabled cycle; ce=0 freezes every register and masks p_valid.
module dsp_mac_engine #(
    parameter int AW      = 18,
    parameter int BW      = 18,
    parameter int PW      = 48,
    parameter int DOT_LEN = 8,
    parameter int SAT_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    dsp_mac_engine_if.slave  bus
);
    localparam int MW = AW + BW + 1;
    localparam int SW = PW + 1;
    localparam logic [7:0] DOT_LAST = 8'(DOT_LEN - 1);

    if (PW < AW + BW + 1 || DOT_LEN < 2 || DOT_LEN > 256) begin : g_param_check
        $error("dsp_mac_engine: PW must be >= AW+BW+1 and DOT_LEN within 2..256");
    end

    // Stage 1: input capture
    logic [AW-1:0] a1_q;
    logic [BW-1:0] b1_q;
    logic [BW-1:0] d1_q;
    logic [PW-1:0] c1_q;
    logic [5:0]    op1_q;
    logic          ci1_q;
    logic          v1_q;

    // Stage 2: pre-adder result with A and the post-add controls delayed alongside
    logic [BW:0]   pre2_d;
    logic [BW:0]   pre2_q;
    logic [AW-1:0] a2_q;
    logic [PW-1:0] c2_q;
    logic [5:2]    op2_q;
    logic          ci2_q;
    logic          v2_q;

    // Stage 3: product register
    logic [MW-1:0] m_d;
    logic [MW-1:0] m_q;
    logic [PW-1:0] c3_q;
    logic [5:2]    op3_q;
    logic          ci3_q;
    logic          v3_q;

    // Stage 4: post-adder, accumulator and dot-product counter
    logic [PW-1:0] z;
    logic [SW-1:0] m_ext;
    logic [SW-1:0] sum;
    logic [PW-1:0] p_d, p_q;
    logic          co_d, co_q;
    logic          sat_d, sat_q;
    logic          pv_d, pv_q;
    logic [7:0]    cnt_d, cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q  <= '0;
            b1_q  <= '0;
            d1_q  <= '0;
            c1_q  <= '0;
            op1_q <= '0;
            ci1_q <= 1'b0;
            v1_q  <= 1'b0;
        end else if (bus.ce) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                a1_q  <= bus.a;
                b1_q  <= bus.b;
                d1_q  <= bus.d;
                c1_q  <= bus.c;
                op1_q <= bus.opmode;
                ci1_q <= bus.carryin;
            end
        end
    end

    // D-B wraps modulo 2^(BW+1); the extra bit keeps D+B exact
    always_comb begin
        pre2_d = {1'b0, b1_q};
        if (op1_q[0]) begin
            pre2_d = op1_q[1] ? ({1'b0, d1_q} - {1'b0, b1_q})
                              : ({1'b0, d1_q} + {1'b0, b1_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre2_q <= '0;
            a2_q   <= '0;
            c2_q   <= '0;
            op2_q  <= '0;
            ci2_q  <= 1'b0;
            v2_q   <= 1'b0;
        end else if (bus.ce) begin
            v2_q <= v1_q;
            if (v1_q) begin
                pre2_q <= pre2_d;
                a2_q   <= a1_q;
                c2_q   <= c1_q;
                op2_q  <= op1_q[5:2];
                ci2_q  <= ci1_q;
            end
        end
    end

    assign m_d = MW'(a2_q) * MW'(pre2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            c3_q  <= '0;
            op3_q <= '0;
            ci3_q <= 1'b0;
            v3_q  <= 1'b0;
        end else if (bus.ce) begin
            v3_q <= v2_q;
            if (v2_q) begin
                m_q   <= m_d;
                c3_q  <= c2_q;
                op3_q <= op2_q;
                ci3_q <= ci2_q;
            end
        end
    end

    // Dot mode overrides the Z select: first sample of a group starts from zero
    always_comb begin
        z = '0;
        if (op3_q[5]) begin
            z = (cnt_q == 8'd0) ? '0 : p_q;
        end else begin
            case (op3_q[3:2])
                2'd1:    z = c3_q;
                2'd2:    z = p_q;
                default: z = '0;
            endcase
        end
    end

    // M < 2^PW, so M + CARRYIN never overflows SW bits; bit PW is carry or borrow
    assign m_ext = SW'(m_q) + SW'(ci3_q);
    assign sum   = op3_q[4] ? ({1'b0, z} - m_ext) : ({1'b0, z} + m_ext);

    always_comb begin
        p_d   = p_q;
        co_d  = co_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        pv_d  = 1'b0;
        if (v3_q) begin
            co_d  = sum[PW];
            sat_d = 1'b0;
            p_d   = sum[PW-1:0];
            if (SAT_EN != 0 && sum[PW]) begin
                sat_d = 1'b1;
                p_d   = op3_q[4] ? '0 : '1;
            end
            if (op3_q[5]) begin
                if (cnt_q == DOT_LAST) begin
                    cnt_d = 8'd0;
                    pv_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                cnt_d = 8'd0;
                pv_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            co_q  <= 1'b0;
            sat_q <= 1'b0;
            pv_q  <= 1'b0;
            cnt_q <= '0;
        end else if (bus.ce) begin
            p_q   <= p_d;
            co_q  <= co_d;
            sat_q <= sat_d;
            pv_q  <= pv_d;
            cnt_q <= cnt_d;
        end
    end

    // A pulse held across a stall is shown once, in the first enabled cycle
    assign bus.p_valid  = pv_q & bus.ce;
    assign bus.m        = m_q;
    assign bus.p        = p_q;
    assign bus.carryout = co_q;
    assign bus.sat      = sat_q;
endmodule

// File: tb/tb_dsp_mac_engine.sv
// Bench for dsp_mac_engine: a saturating and a wrapping instance driven in lockstep,
// results checked against an expectation queue filled as samples are issued.
module tb_dsp_mac_engine;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          in_valid;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] d;
    logic [PW-1:0] c;
    logic [5:0]    opmode;
    logic          carryin;

    always #5 clk = ~clk;

    dsp_mac_engine_if #(.AW(AW), .BW(BW), .PW(PW)) ifs ();
    dsp_mac_engine_if #(.AW(AW), .BW(BW), .PW(PW)) ifw ();

    assign ifs.ce = ce;        assign ifw.ce = ce;
    assign ifs.in_valid = in_valid; assign ifw.in_valid = in_valid;
    assign ifs.a = a;          assign ifw.a = a;
    assign ifs.b = b;          assign ifw.b = b;
    assign ifs.d = d;          assign ifw.d = d;
    assign ifs.c = c;          assign ifw.c = c;
    assign ifs.opmode = opmode; assign ifw.opmode = opmode;
    assign ifs.carryin = carryin; assign ifw.carryin = carryin;

    dsp_mac_engine #(.AW(AW), .BW(BW), .PW(PW), .DOT_LEN(DL), .SAT_EN(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave));
    dsp_mac_engine #(.AW(AW), .BW(BW), .PW(PW), .DOT_LEN(DL), .SAT_EN(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(ifw.slave));

    typedef struct {
        logic [AW-1:0]  a;
        logic [BW-1:0]  b;
        logic [BW-1:0]  d;
        logic [PW-1:0]  c;
        logic [5:0]     op;
        logic           ci;
        logic [AW+BW:0] m;
        logic [PW-1:0]  p_s;
        logic [PW-1:0]  p_w;
        logic           co;
        logic           sat_s;
        logic           sat_w;
    } vec_t;

    typedef struct {
        logic [PW-1:0]  p_s;
        logic [PW-1:0]  p_w;
        logic           co;
        logic           sat_s;
        logic           sat_w;
        logic [AW+BW:0] m;
        logic           chk_m;
    } exp_t;

    vec_t tbl[11];
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pv_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic vec_t mkd(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                                 input logic [5:0] op, input logic [PW-1:0] pexp);
        vec_t v;
        v = '{av, bv, 18'd0, 48'd0, op, 1'b0, 37'd0, pexp, pexp, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive(input vec_t v, input bit chk_m, input bit push);
        exp_t e;
        a = v.a; b = v.b; d = v.d; c = v.c; opmode = v.op; carryin = v.ci;
        in_valid = 1'b1;
        if (push) begin
            e = '{v.p_s, v.p_w, v.co, v.sat_s, v.sat_w, v.m, chk_m};
            sb.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input vec_t v, input string name);
        int lat = 0;
        exp_t e;
        a = v.a; b = v.b; d = v.d; c = v.c; opmode = v.op; carryin = v.ci;
        in_valid = 1'b1;
        e = '{v.p_s, v.p_w, v.co, v.sat_s, v.sat_w, v.m, 1'b1};
        sb.push_back(e);
        for (int i = 1; i <= 8; i++) begin
            step();
            in_valid = 1'b0;
            if (lat == 0 && ifs.p_valid) lat = i;
        end
        chk(name, 64'(lat), 64'd4);
    endtask

    always @(negedge clk) begin
        if (rst_n && ifs.p_valid) begin
            pv_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_p_valid: P=%0d arrived with no result pending at %0t", ifs.p, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("p_sat",        64'(ifs.p),        64'(mon_e.p_s));
                chk("carryout_sat", 64'(ifs.carryout), 64'(mon_e.co));
                chk("sat_flag_sat", 64'(ifs.sat),      64'(mon_e.sat_s));
                chk("p_wrap",       64'(ifw.p),        64'(mon_e.p_w));
                chk("carryout_wrap", 64'(ifw.carryout), 64'(mon_e.co));
                chk("sat_flag_wrap", 64'(ifw.sat),     64'(mon_e.sat_w));
                chk("p_valid_wrap", 64'(ifw.p_valid),  64'd1);
                if (mon_e.chk_m) chk("m", 64'(ifs.m), 64'(mon_e.m));
            end
        end
    end

    initial begin
        int pv0;
        logic [PW-1:0]  snap_p;
        logic [AW+BW:0] snap_m;

        //            a        b        d        c                  op     ci  m                 p_sat                p_wrap               co sat_s sat_w
        tbl[0]  = '{20,      50,      100,     10,                6'h05, 0,  3000,             3000+10,             3010,                0, 0, 0};
        tbl[1]  = '{10,      30,      50,      500,               6'h17, 0,  200,              300,                 300,                 0, 0, 0};
        tbl[2]  = '{3,       7,       0,       0,                 6'h00, 0,  21,               21,                  21,                  0, 0, 0};
        tbl[3]  = '{2,       5,       0,       0,                 6'h08, 1,  10,               32,                  32,                  0, 0, 0};
        tbl[4]  = '{1,       4,       0,       100,               6'h0C, 0,  4,                4,                   4,                   0, 0, 0};
        tbl[5]  = '{1,       10,      0,       5,                 6'h14, 0,  10,               0,                   48'hFFFF_FFFF_FFFB,  1, 1, 0};
        tbl[6]  = '{1,       3,       1,       0,                 6'h03, 0,  524286,           524286,              524286,              0, 0, 0};
        tbl[7]  = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 0,          6'h01, 0,  37'd137437904898, 48'd137437904898,    48'd137437904898,    0, 0, 0};
        tbl[8]  = '{1,       2,       0,       0,                 6'h18, 1,  2,                48'd137437904895,    48'd137437904895,    0, 0, 0};
        tbl[9]  = '{0,       0,       0,       48'hFFFF_FFFF_FFFF, 6'h04, 0, 0,                48'hFFFF_FFFF_FFFF,  48'hFFFF_FFFF_FFFF,  0, 0, 0};
        tbl[10] = '{1,       1,       0,       0,                 6'h09, 0,  1,                48'hFFFF_FFFF_FFFF,  48'd0,               1, 1, 0};

        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0;
        a = '0; b = '0; d = '0; c = '0; opmode = '0; carryin = 1'b0;

        // Reset held with traffic present: everything stays cleared
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 18'($urandom); b = 18'($urandom); c = 48'($urandom); opmode = 6'h05;
            @(negedge clk);
            chk("rst_m",        64'(ifs.m),        64'd0);
            chk("rst_p",        64'(ifs.p),        64'd0);
            chk("rst_p_valid",  64'(ifs.p_valid),  64'd0);
            chk("rst_carryout", 64'(ifs.carryout), 64'd0);
            chk("rst_sat",      64'(ifs.sat),      64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        lat_check(tbl[0], "latency_after_reset");

        // Back-to-back table: one result per cycle
        pv0 = pv_cnt;
        for (int i = 0; i < 11; i++) drive(tbl[i], 1'b0, 1'b1);
        idle(3);
        @(negedge clk);
        #1;
        chk("throughput_pulses", 64'(pv_cnt - pv0), 64'd11);
        idle(2);

        // Same table with a bubble between samples so M can be observed per result
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i], 1'b1, 1'b1);
            idle(1);
        end
        idle(4);

        // Dot product with a bubble mid-group, then a fresh group
        drive(mkd(1, 2, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(2, 2, 6'h21, 0), 1'b0, 1'b0);
        idle(1);
        drive(mkd(3, 2, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(4, 2, 6'h21, 20), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(mkd(1, 1, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(1, 1, 6'h21, 4), 1'b0, 1'b1);
        // Non-dot sample mid-group aborts the count and accumulates normally
        drive(mkd(5, 1, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(5, 1, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(1, 1, 6'h08, 11), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(mkd(1, 1, 6'h21, 0), 1'b0, 1'b0);
        drive(mkd(1, 1, 6'h21, 4), 1'b0, 1'b1);
        idle(5);

        // CE stall with a result pending; junk offered while stalled must be ignored
        for (int i = 0; i < 4; i++) drive(tbl[i], 1'b0, 1'b1);
        ce = 1'b0;
        in_valid = 1'b1; a = 18'd777; b = 18'd777; opmode = 6'h00;
        snap_p = ifs.p;
        snap_m = ifs.m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_p_frozen", 64'(ifs.p), 64'(snap_p));
            chk("stall_m_frozen", 64'(ifs.m), 64'(snap_m));
            chk("stall_no_pvalid", 64'(ifs.p_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        drive(tbl[4], 1'b0, 1'b1);
        drive(tbl[5], 1'b0, 1'b1);
        idle(5);

        // Asynchronous reset between edges discards in-flight work
        drive(tbl[0], 1'b0, 1'b1);
        idle(4);
        drive(tbl[1], 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_p",        64'(ifs.p),        64'd0);
        chk("async_rst_m",        64'(ifs.m),        64'd0);
        chk("async_rst_p_valid",  64'(ifs.p_valid),  64'd0);
        chk("async_rst_carryout", 64'(ifw.carryout), 64'd0);
        chk("async_rst_sat",      64'(ifs.sat),      64'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        lat_check(tbl[2], "latency_after_async_reset");
        idle(4);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
